regfile_arbiter: RTL and testbench



---
 rtl/regfile_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter that sequences single read/write commands from NREQ requesters onto one register-file port.
// Define REGFILE_ARBITER_PRIO0_EN to give requester 0 fixed priority over a round-robin among the others.
module regfile_arbiter #(
  parameter int NREQ         = 2,
  parameter int R_ADDR_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              i_req,
  input  logic [NREQ-1:0]              i_we,
  input  logic [NREQ*R_ADDR_WIDTH-1:0] i_addr,
  input  logic [NREQ*32-1:0]           i_wdata,
  output logic [NREQ-1:0]              o_ack,
  output logic [31:0]                  o_rdata,
  output logic                         o_busy,
  output logic                         o_rd,
  output logic                         o_wr,
  output logic [R_ADDR_WIDTH-1:0]      o_rreg,
  output logic [R_ADDR_WIDTH-1:0]      o_wreg,
  output logic [31:0]                  o_wdata,
  input  logic [31:0]                  i_rdata
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef REGFILE_ARBITER_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [GW-1:0]           grant_reg, grant_next;
  logic [GW-1:0]           last_reg, last_next;
  logic                    we_reg, we_next;
  logic                    rd_reg, rd_next;
  logic                    wr_reg, wr_next;
  logic [R_ADDR_WIDTH-1:0] rreg_reg, rreg_next;
  logic [R_ADDR_WIDTH-1:0] wreg_reg, wreg_next;
  logic [31:0]             wdata_reg, wdata_next;
  logic [31:0]             rdata_reg, rdata_next;
  logic [NREQ-1:0]         ack_reg, ack_next;

  logic [R_ADDR_WIDTH-1:0] addr_arr  [NREQ];
  logic [31:0]             wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = i_addr[gi*R_ADDR_WIDTH +: R_ADDR_WIDTH];
      assign wdata_arr[gi] = i_wdata[gi*32 +: 32];
    end
  endgenerate

  // Requester 0 leaves the rotation when it has fixed priority.
  logic [NREQ-1:0] rr_req;
  assign rr_req = PRIO0 ? (i_req & ~NREQ'(1)) : i_req;

  // Rotating search: first requester above last wins, otherwise wrap to the lowest.
  logic          hi_valid, lo_valid, win_valid;
  logic [GW-1:0] hi_idx, lo_idx, win_idx;

  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (rr_req[k]) begin
        if (k > int'(last_reg)) begin
          if (!hi_valid) begin
            hi_valid = 1'b1;
            hi_idx   = GW'(k);
          end
        end else if (!lo_valid) begin
          lo_valid = 1'b1;
          lo_idx   = GW'(k);
        end
      end
    end
    win_valid = hi_valid | lo_valid;
    win_idx   = hi_valid ? hi_idx : lo_idx;
    if (PRIO0 && i_req[0]) begin
      win_valid = 1'b1;
      win_idx   = '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    we_next    = we_reg;
    rd_next    = 1'b0;
    wr_next    = 1'b0;
    rreg_next  = rreg_reg;
    wreg_next  = wreg_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    ack_next   = '0;
    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          state_next = ISSUE;
          grant_next = win_idx;
          last_next  = (PRIO0 && win_idx == '0) ? last_reg : win_idx;
          we_next    = i_we[win_idx];
          if (i_we[win_idx]) begin
            wr_next    = 1'b1;
            wreg_next  = addr_arr[win_idx];
            wdata_next = wdata_arr[win_idx];
          end else begin
            rd_next    = 1'b1;
            rreg_next  = addr_arr[win_idx];
          end
        end
      end
      ISSUE: begin
        if (we_reg) begin
          state_next          = ACK;
          ack_next[grant_reg] = 1'b1;
        end else begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next          = ACK;
        rdata_next          = i_rdata;
        ack_next[grant_reg] = 1'b1;
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= GW'(NREQ - 1);
      we_reg    <= 1'b0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      rreg_reg  <= '0;
      wreg_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      ack_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      we_reg    <= we_next;
      rd_reg    <= rd_next;
      wr_reg    <= wr_next;
      rreg_reg  <= rreg_next;
      wreg_reg  <= wreg_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      ack_reg   <= ack_next;
    end
  end

  assign o_ack   = ack_reg;
  assign o_rdata = rdata_reg;
  assign o_busy  = (state_reg != IDLE);
  assign o_rd    = rd_reg;
  assign o_wr    = wr_reg;
  assign o_rreg  = rreg_reg;
  assign o_wreg  = wreg_reg;
  assign o_wdata = wdata_reg;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: transaction-schedule model compared every cycle, plus directed literal checks.
module tb_regfile_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      i_req = '0;
  logic [NREQ-1:0]      i_we = '0;
  logic [NREQ*AW-1:0]   i_addr = '0;
  logic [NREQ*32-1:0]   i_wdata = '0;
  logic [31:0]          i_rdata = '0;
  logic [NREQ-1:0]      o_ack;
  logic [31:0]          o_rdata;
  logic                 o_busy, o_rd, o_wr;
  logic [AW-1:0]        o_rreg, o_wreg;
  logic [31:0]          o_wdata;

  regfile_arbiter #(.NREQ(NREQ), .R_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_ack(o_ack), .o_rdata(o_rdata), .o_busy(o_busy),
    .o_rd(o_rd), .o_wr(o_wr), .o_rreg(o_rreg), .o_wreg(o_wreg),
    .o_wdata(o_wdata), .i_rdata(i_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file attached to the DUT port: data appears on the edge after the read strobe.
  logic [31:0] rf_mem [4] = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222, 32'h1234_5678};
  always @(posedge clk) begin
    if (o_wr) rf_mem[o_wreg] <= o_wdata;
    if (o_rd) i_rdata <= rf_mem[o_rreg];
  end

  // Reference model: each granted command is a timeline relative to its grant edge t0.
  logic [31:0]     m_mem [4] = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222, 32'h1234_5678};
  int              cyc = 0;
  int              d;
  int              txn_no = 0;
  bit              m_act = 1'b0;
  int              m_t0 = 0;
  int              m_g = 0;
  bit              m_we = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  logic [31:0]     m_wd = '0;
  int              m_last = NREQ - 1;
  bit              exp_rd = 1'b0, exp_wr = 1'b0, exp_busy = 1'b0;
  logic [NREQ-1:0] exp_ack = '0;
  logic [AW-1:0]   exp_rreg = '0, exp_wreg = '0;
  logic [31:0]     exp_wdata = '0, exp_rdata = '0;

  function automatic int pick(input logic [NREQ-1:0] req, input int last);
`ifdef REGFILE_ARBITER_PRIO0_EN
    if (req[0]) return 0;
`endif
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (last + i) % NREQ;
`ifdef REGFILE_ARBITER_PRIO0_EN
      if (k != 0 && ((req >> k) & NREQ'(1)) != 0) return k;
`else
      if (((req >> k) & NREQ'(1)) != 0) return k;
`endif
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_act = 1'b0; m_last = NREQ - 1;
        exp_rd = 1'b0; exp_wr = 1'b0; exp_busy = 1'b0; exp_ack = '0;
        exp_rreg = '0; exp_wreg = '0; exp_wdata = '0; exp_rdata = '0;
      end else begin
        cyc++;
        exp_rd = 1'b0; exp_wr = 1'b0; exp_ack = '0;
        if (m_act) begin
          d = cyc - m_t0;
          if (d == (m_we ? 1 : 2)) begin
            exp_ack = NREQ'(1) << m_g;
            if (!m_we) exp_rdata = m_mem[m_addr];
            txn_no++;
            $display("txn %0d: req%0d %s reg=%0d data=0x%08h", txn_no, m_g,
                     m_we ? "write" : "read ", m_addr, m_we ? m_wd : m_mem[m_addr]);
          end
          if (d == (m_we ? 2 : 3)) m_act = 1'b0;
        end else if (i_req != '0) begin
          m_g    = pick(i_req, m_last);
          m_act  = 1'b1;
          m_t0   = cyc;
          m_we   = ((i_we >> m_g) & NREQ'(1)) != 0;
          m_addr = AW'(i_addr >> (m_g * AW));
          m_wd   = 32'(i_wdata >> (m_g * 32));
`ifdef REGFILE_ARBITER_PRIO0_EN
          if (m_g != 0) m_last = m_g;
`else
          m_last = m_g;
`endif
          if (m_we) begin
            exp_wr = 1'b1; exp_wreg = m_addr; exp_wdata = m_wd; m_mem[m_addr] = m_wd;
          end else begin
            exp_rd = 1'b1; exp_rreg = m_addr;
          end
        end
        exp_busy = m_act;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("rd", o_rd, exp_rd);
      check("wr", o_wr, exp_wr);
      check("ack", o_ack, exp_ack);
      check("busy", o_busy, exp_busy);
      check("rreg", o_rreg, exp_rreg);
      check("wreg", o_wreg, exp_wreg);
      check("wdata", o_wdata, exp_wdata);
      check("rdata", o_rdata, exp_rdata);
      check("rd_wr_excl", o_rd & o_wr, 0);
    end
  end

  task automatic new_cmd(input int k, input int max_addr);
    i_we[k] = 1'($urandom_range(0, 1));
    i_addr[k*AW +: AW] = AW'($urandom_range(0, max_addr));
    i_wdata[k*32 +: 32] = $urandom;
    i_req[k] = 1'b1;
  endtask

  task automatic wait_ack(input string name, output logic [NREQ-1:0] a);
    a = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_ack != '0) begin
        a = o_ack;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: got no ack within 40 cycles, required one", name);
  endtask

  task automatic drive_random(input bit issuing);
    for (int k = 0; k < NREQ; k++) begin
      if (i_req[k]) begin
        if (o_ack[k]) begin
          if (issuing && $urandom_range(0, 1) == 1) new_cmd(k, 3);
          else i_req[k] = 1'b0;
        end
      end else if (issuing && $urandom_range(0, 3) == 0) begin
        new_cmd(k, 3);
      end
    end
  endtask

  logic [NREQ-1:0] a;
  logic [NREQ-1:0] exp_a;
  bit              seen;

  initial begin
    // Reset with both requesters pending writes.
    i_req = 2'b11; i_we = 2'b11;
    i_addr = {2'd2, 2'd1};
    i_wdata = {32'h2222_2222, 32'h1111_1111};
    repeat (3) @(negedge clk);
    check("reset_busy", o_busy, 0);
    check("reset_ack", o_ack, 0);
    check("reset_strobes", {o_rd, o_wr}, 0);
    check("reset_rdata", o_rdata, 0);
    #2 rst_n = 1'b1;
    wait_ack("first_grant", a);
    check("first_grant", a, 2'b01);
    i_req[0] = 1'b0;
    wait_ack("second_grant", a);
    check("second_grant", a, 2'b10);
    i_req = '0;
    repeat (2) @(negedge clk);

    // Single write from requester 0.
    i_req = 2'b01; i_we = 2'b01; i_addr = {2'd0, 2'd2}; i_wdata[31:0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("sw_wr", o_wr, 1);
    check("sw_wreg", o_wreg, 2);
    check("sw_wdata", o_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("sw_ack", o_ack, 2'b01);
    check("sw_wr_low", o_wr, 0);
    i_req = '0;
    @(negedge clk);
    check("sw_ack_once", o_ack, 0);
    repeat (2) @(negedge clk);

    // Single read from requester 1.
    i_req = 2'b10; i_we = 2'b00; i_addr = {2'd3, 2'd0};
    @(negedge clk);
    check("sr_rd", o_rd, 1);
    check("sr_rreg", o_rreg, 3);
    @(negedge clk);
    check("sr_rd_low", o_rd, 0);
    check("sr_no_early_ack", o_ack, 0);
    @(negedge clk);
    check("sr_ack", o_ack, 2'b10);
    check("sr_rdata", o_rdata, 32'h1234_5678);
    i_req = '0;
    @(negedge clk);
    check("sr_ack_once", o_ack, 0);
    repeat (2) @(negedge clk);

    // Contention: both requesters held for 8 commands.
    new_cmd(0, 2);
    new_cmd(1, 2);
    for (int n = 0; n < 8; n++) begin
      wait_ack("contention", a);
`ifdef REGFILE_ARBITER_PRIO0_EN
      exp_a = 2'b01;
`else
      exp_a = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
      check("contention_grant", a, exp_a);
      for (int k = 0; k < NREQ; k++) if (a[k]) new_cmd(k, 2);
    end
    i_req[0] = 1'b0;
    wait_ack("drop_req0", a);
    check("drop_req0_grant", a, 2'b10);
    i_req = '0;
    repeat (3) @(negedge clk);

    // Reset during CAPTURE of a read.
    i_req = 2'b01; i_we = 2'b00; i_addr = {2'd0, 2'd3};
    @(negedge clk);
    check("mr_rd", o_rd, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy_clr", o_busy, 0);
    check("mr_no_ack", o_ack, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (o_rd) seen = 1'b1;
    end
    check("mr_reissue_rd", seen, 1);
    check("mr_reissue_rreg", o_rreg, 3);
    wait_ack("mr_ack", a);
    check("mr_ack", a, 2'b01);
    check("mr_rdata", o_rdata, 32'h1234_5678);
    i_req = '0;
    repeat (2) @(negedge clk);

    // Random traffic, then drain.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive_random(1'b1);
    end
    for (int c = 0; c < 200 && i_req != '0; c++) begin
      @(negedge clk);
      drive_random(1'b0);
    end
    check("drain_req", i_req, 0);
    repeat (4) @(negedge clk);
    check("end_busy", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
